// File: rtl/sap1_controller.sv
// SAP-1 control sequencer.
// Walks a six-step T-cycle ring (T1-T3 fetch, T4-T6 execute), decodes the
// IR opcode nibble during execute and owns every bus-source enable plus all
// register load/increment strobes of the datapath. Outputs are Moore-decoded
// from the registered T-state, qualified by the opcode during T4-T6.
module sap1_controller (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic [3:0] opcode_i,
    output logic       pc_en_o,
    output logic       ram_en_o,
    output logic       ir_en_o,
    output logic       accu_en_o,
    output logic       adder_en_o,
    output logic       sub_o,
    output logic       pc_inc_o,
    output logic       mar_load_o,
    output logic       ir_load_o,
    output logic       accu_load_o,
    output logic       breg_load_o,
    output logic       out_load_o,
    output logic [5:0] t_state_o,
    output logic       halted_o
);

    // Instruction set
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Sequencer states; code 7 is unused and recovers to T1
    localparam logic [2:0] S_T1   = 3'd0;
    localparam logic [2:0] S_T2   = 3'd1;
    localparam logic [2:0] S_T3   = 3'd2;
    localparam logic [2:0] S_T4   = 3'd3;
    localparam logic [2:0] S_T5   = 3'd4;
    localparam logic [2:0] S_T6   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    // One bundle for every datapath control line so decode and gating
    // treat them uniformly
    typedef struct packed {
        logic pc_en;
        logic ram_en;
        logic ir_en;
        logic accu_en;
        logic adder_en;
        logic sub;
        logic pc_inc;
        logic mar_load;
        logic ir_load;
        logic accu_load;
        logic breg_load;
        logic out_load;
    } ctrl_t;

    logic [2:0] state_q;
    logic [2:0] state_d;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;

    // Next T-state: advance only while running; HLT diverts T4 into HALT,
    // and HALT is left only through reset
    always_comb begin
        state_d = state_q;
        if (state_q == S_HALT) begin
            state_d = S_HALT;
        end else if (run_i) begin
            case (state_q)
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_T3:    state_d = S_T4;
                S_T4:    state_d = (opcode_i == OP_HLT) ? S_HALT : S_T5;
                S_T5:    state_d = S_T6;
                S_T6:    state_d = S_T1;
                default: state_d = S_T1;
            endcase
        end
    end

    // State register with synchronous reset back to T1
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Control decode: fetch is opcode-independent, execute looks at the
    // opcode. Each step enables at most one bus source by construction.
    always_comb begin
        ctrl_raw = '0;
        case (state_q)
            S_T1: begin
                ctrl_raw.pc_en    = 1'b1;
                ctrl_raw.mar_load = 1'b1;
            end
            S_T2: begin
                ctrl_raw.pc_inc = 1'b1;
            end
            S_T3: begin
                ctrl_raw.ram_en  = 1'b1;
                ctrl_raw.ir_load = 1'b1;
            end
            S_T4: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl_raw.ir_en    = 1'b1;
                        ctrl_raw.mar_load = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_raw.accu_en  = 1'b1;
                        ctrl_raw.out_load = 1'b1;
                    end
                    default: ctrl_raw = '0;
                endcase
            end
            S_T5: begin
                case (opcode_i)
                    OP_LDA: begin
                        ctrl_raw.ram_en    = 1'b1;
                        ctrl_raw.accu_load = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_raw.ram_en    = 1'b1;
                        ctrl_raw.breg_load = 1'b1;
                    end
                    default: ctrl_raw = '0;
                endcase
            end
            S_T6: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    ctrl_raw.adder_en  = 1'b1;
                    ctrl_raw.accu_load = 1'b1;
                    ctrl_raw.sub       = (opcode_i == OP_SUB);
                end
            end
            default: ctrl_raw = '0;
        endcase
    end

    // Suppress all strobes during reset and pause so a held state never
    // loads or increments twice; HALT already decodes to all-zero
    always_comb begin
        ctrl = ctrl_raw;
        if (rst_i || !run_i) begin
            ctrl = '0;
        end
    end

    // One-hot T-state view; blank in HALT, forced to T1 while in reset
    always_comb begin
        t_state_o = 6'b000000;
        if (rst_i) begin
            t_state_o = 6'b000001;
        end else begin
            case (state_q)
                S_T1:    t_state_o = 6'b000001;
                S_T2:    t_state_o = 6'b000010;
                S_T3:    t_state_o = 6'b000100;
                S_T4:    t_state_o = 6'b001000;
                S_T5:    t_state_o = 6'b010000;
                S_T6:    t_state_o = 6'b100000;
                default: t_state_o = 6'b000000;
            endcase
        end
    end

    assign halted_o    = !rst_i && (state_q == S_HALT);

    assign pc_en_o     = ctrl.pc_en;
    assign ram_en_o    = ctrl.ram_en;
    assign ir_en_o     = ctrl.ir_en;
    assign accu_en_o   = ctrl.accu_en;
    assign adder_en_o  = ctrl.adder_en;
    assign sub_o       = ctrl.sub;
    assign pc_inc_o    = ctrl.pc_inc;
    assign mar_load_o  = ctrl.mar_load;
    assign ir_load_o   = ctrl.ir_load;
    assign accu_load_o = ctrl.accu_load;
    assign breg_load_o = ctrl.breg_load;
    assign out_load_o  = ctrl.out_load;

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: the stimulus process drives one cycle
// at a time and queues the expected outputs from an instruction-level model;
// a monitor on the falling edge pops and compares.
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       run_i = 1'b0;
    logic [3:0] opcode_i = 4'h0;
    logic       pc_en_o, ram_en_o, ir_en_o, accu_en_o, adder_en_o, sub_o;
    logic       pc_inc_o, mar_load_o, ir_load_o, accu_load_o, breg_load_o, out_load_o;
    logic [5:0] t_state_o;
    logic       halted_o;

    sap1_controller dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .run_i      (run_i),
        .opcode_i   (opcode_i),
        .pc_en_o    (pc_en_o),
        .ram_en_o   (ram_en_o),
        .ir_en_o    (ir_en_o),
        .accu_en_o  (accu_en_o),
        .adder_en_o (adder_en_o),
        .sub_o      (sub_o),
        .pc_inc_o   (pc_inc_o),
        .mar_load_o (mar_load_o),
        .ir_load_o  (ir_load_o),
        .accu_load_o(accu_load_o),
        .breg_load_o(breg_load_o),
        .out_load_o (out_load_o),
        .t_state_o  (t_state_o),
        .halted_o   (halted_o)
    );

    always #5 clk = ~clk;

    // Control word bit names (bit order: pc_en .. out_load)
    localparam logic [11:0] PC_EN = 12'h800, RAM_EN = 12'h400, IR_EN = 12'h200,
                            AC_EN = 12'h100, AD_EN = 12'h080, SUB = 12'h040,
                            PC_INC = 12'h020, MAR_LD = 12'h010, IR_LD = 12'h008,
                            AC_LD = 12'h004, B_LD = 12'h002, OUT_LD = 12'h001;

    typedef struct packed {
        logic [11:0] ctl;
        logic [5:0]  t;
        logic        h;
    } obs_t;

    typedef struct {
        obs_t  exp;
        string name;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    // Instruction-level model: current step 1..6 and halt flag
    int m_step = 1;
    bit m_halt = 1'b0;

    // Strobes the datapath needs at a given step of a given instruction
    function automatic logic [11:0] strobes(input int step, input logic [3:0] op);
        case (step)
            1: return PC_EN | MAR_LD;
            2: return PC_INC;
            3: return RAM_EN | IR_LD;
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) return IR_EN | MAR_LD;
                if (op == 4'hE) return AC_EN | OUT_LD;
                return 12'h000;
            end
            5: begin
                if (op == 4'h0) return RAM_EN | AC_LD;
                if (op == 4'h1 || op == 4'h2) return RAM_EN | B_LD;
                return 12'h000;
            end
            6: begin
                if (op == 4'h1) return AD_EN | AC_LD;
                if (op == 4'h2) return AD_EN | AC_LD | SUB;
                return 12'h000;
            end
            default: return 12'h000;
        endcase
    endfunction

    function automatic obs_t model_obs(input logic r, input logic run, input logic [3:0] op);
        obs_t o;
        if (r) begin
            o.ctl = 12'h000; o.t = 6'b000001; o.h = 1'b0;
        end else if (m_halt) begin
            o.ctl = 12'h000; o.t = 6'b000000; o.h = 1'b1;
        end else begin
            o.ctl = run ? strobes(m_step, op) : 12'h000;
            o.t   = 6'(1 << (m_step - 1));
            o.h   = 1'b0;
        end
        return o;
    endfunction

    // One clock of stimulus: drive, queue expectation, advance the model
    task automatic cyc(input logic r, input logic run, input logic [3:0] op);
        item_t it;
        @(posedge clk);
        #1;
        rst_i = r; run_i = run; opcode_i = op;
        it.exp  = model_obs(r, run, op);
        it.name = phase;
        q.push_back(it);
        if (r) begin
            m_step = 1; m_halt = 1'b0;
        end else if (!m_halt && run) begin
            if (m_step == 4 && op == 4'hF) m_halt = 1'b1;
            else m_step = (m_step % 6) + 1;
        end
    endtask

    // Full six-cycle instruction with run held high
    task automatic instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, op);
    endtask

    // Monitor: compare each presented cycle against the scoreboard and
    // check the single-bus-driver rule on every cycle
    always @(negedge clk) begin
        obs_t  act;
        item_t it;
        act.ctl = {pc_en_o, ram_en_o, ir_en_o, accu_en_o, adder_en_o, sub_o,
                   pc_inc_o, mar_load_o, ir_load_o, accu_load_o, breg_load_o, out_load_o};
        act.t = t_state_o;
        act.h = halted_o;
        total++;
        if ($countones({pc_en_o, ram_en_o, ir_en_o, accu_en_o, adder_en_o}) > 1) begin
            bad++;
            $display("FAIL bus_onehot at %0t: enables=%b required at most one set", $time,
                     {pc_en_o, ram_en_o, ir_en_o, accu_en_o, adder_en_o});
        end
        if (q.size() > 0) begin
            it = q.pop_front();
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s at %0t: got ctl=%b t=%b h=%b, expected ctl=%b t=%b h=%b",
                         it.name, $time, act.ctl, act.t, act.h, it.exp.ctl, it.exp.t, it.exp.h);
            end
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic       r;
        logic       run;

        // Reset held three cycles, then the fetch of an ADD
        phase = "reset";
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'($urandom));
        phase = "add";
        instr(4'h1);
        phase = "sub";
        instr(4'h2);

        // LDA paused for four cycles while sitting in T5
        phase = "lda_pause";
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);

        phase = "undef_op";
        instr(4'h5);
        phase = "out";
        instr(4'hE);

        // HLT, then sit in HALT with run toggling, then reset out of it
        phase = "hlt";
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 4'hF);
        phase = "halted";
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2), 4'($urandom));
        phase = "halt_reset";
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);

        // Random instruction stream with pauses and occasional resets
        phase = "random";
        op = 4'($urandom);
        for (int i = 0; i < 1000; i++) begin
            if (m_step == 1 && !m_halt) op = 4'($urandom_range(0, 15));
            run = ($urandom_range(0, 3) != 0);
            r   = m_halt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            cyc(r, run, op);
        end

        // Drain, then confirm every queued expectation was checked
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
- Control sequencer for the SAP-1 datapath.
- Runs a 6-state T-cycle ring (fetch T1–T3, execute T4–T6).
- Decodes the IR opcode nibble and drives the bus-source enables (pc/ram/ir/accu/adder) plus all register load and increment strobes.
- Guarantees at most one bus driver per cycle; sits beside the bus mux and owns every datapath control line.

Parameters:
- OP_LDA, 4'b0000, load accumulator from RAM[addr]
- OP_ADD, 4'b0001, A <= A + RAM[addr]
- OP_SUB, 4'b0010, A <= A - RAM[addr]
- OP_OUT, 4'b1110, output register <= A
- OP_HLT, 4'b1111, stop sequencing

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  synchronous, active-high reset
- run_i  input  1  1 = advance T-state each clock; 0 = pause
- opcode_i  input  4  IR upper nibble; valid from T4 onward
- pc_en_o  output  1  PC drives bus
- ram_en_o  output  1  RAM drives bus
- ir_en_o  output  1  IR address nibble drives bus
- accu_en_o  output  1  accumulator drives bus
- adder_en_o  output  1  adder/subtractor drives bus
- sub_o  output  1  adder in subtract mode
- pc_inc_o  output  1  PC increments at clock edge
- mar_load_o  output  1  MAR loads bus
- ir_load_o  output  1  IR loads bus
- accu_load_o  output  1  accumulator loads bus
- breg_load_o  output  1  B register loads bus
- out_load_o  output  1  output register loads bus
- t_state_o  output  6  one-hot T-state, bit0 = T1
- halted_o  output  1  HLT executed

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_i is synchronous and active-high.
- States: T1..T6 plus HALT; state is registered.
- Outputs are decoded from the registered state (Moore). opcode_i is additionally used in T4–T6.
- Output validity: outputs are valid for the whole state; datapath registers sample on the rising edge that ends the state.
- Reset:
  - rst_i=1 at an edge -> state T1, halted_o=0.
  - While rst_i=1, all control outputs are forced 0 and t_state_o=6'b000001.
  - Reset mid-instruction or in HALT aborts and restarts at T1.
- Pause:
  - run_i=0 -> state held and all control outputs forced 0 (no double loads or increments).
  - t_state_o still shows the held state.
  - Resume re-issues the held state's controls for one cycle.
- Advance: with run_i=1, Tn -> Tn+1 each clock; T6 -> T1.
- Fetch (opcode-independent):
  - T1: pc_en_o, mar_load_o
  - T2: pc_inc_o
  - T3: ram_en_o, ir_load_o
- Execute by opcode:
  - LDA: T4 ir_en_o, mar_load_o; T5 ram_en_o, accu_load_o; T6 none.
  - ADD: T4 ir_en_o, mar_load_o; T5 ram_en_o, breg_load_o; T6 adder_en_o, accu_load_o, sub_o=0.
  - SUB: same as ADD but sub_o=1 during T6 only.
  - OUT: T4 accu_en_o, out_load_o; T5/T6 none.
  - HLT: T4 no strobes; the T4 -> next transition goes to HALT instead of T5.
  - Any other opcode: NOP; T4–T6 have no strobes.
- HALT:
  - All control outputs 0, halted_o=1, t_state_o=0.
  - Remains in HALT regardless of run_i; only rst_i exits.
- sub_o is 0 everywhere except SUB T6.
- Invariant: at most one of pc_en_o/ram_en_o/ir_en_o/accu_en_o/adder_en_o is high in any cycle.
- Latency: non-HLT instruction = 6 run cycles; HLT reaches HALT 4 run cycles after T1.

Test Plan:
- Reset held 3 cycles, release with run_i=1 -> cycle0 T1: pc_en_o=1, mar_load_o=1; cycle1 pc_inc_o=1; cycle2 ram_en_o=1, ir_load_o=1.
- opcode_i=4'b0001 (ADD) -> T4 ir_en_o+mar_load_o, T5 ram_en_o+breg_load_o, T6 adder_en_o+accu_load_o with sub_o=0, then T1.
- opcode_i=4'b0010 (SUB) -> T6 adder_en_o=accu_load_o=sub_o=1; sub_o=0 in all other states.
- opcode_i=4'b1110 then 4'b1111 -> OUT T4 accu_en_o+out_load_o; HLT enters HALT with halted_o=1 after its T4 and holds 20 cycles with run_i toggling; rst_i returns to T1 with halted_o=0.
- run_i dropped during LDA T5 for 4 cycles -> outputs all 0, t_state_o=6'b010000 held; on resume ram_en_o+accu_load_o asserted for exactly 1 cycle.
- Random opcodes including 4'b0101 over 1000 cycles -> bus-enable one-hot-or-zero assertion never fails; undefined opcode gives no strobes in T4–T6.
